// File: rtl/mpi_pkg.sv
// Shared fp16 operand types and collector state encoding for the operand packer.
package mpi_pkg;

  typedef logic [15:0] fp16_t;

  localparam fp16_t FP16_ONE  = 16'h3C00;
  localparam fp16_t FP16_ZERO = 16'h0000;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } col_state_t;

endpackage : mpi_pkg

// File: rtl/operand_packer.sv
// Packs a stream of fp16 words into N-lane vectors with frame start/last flags.
// Build option: OPERAND_PACKER_PAD_ONE_EN pads unfilled lanes with fp16 1.0 instead of 0.
module operand_packer
  import mpi_pkg::*;
#(
  parameter int N = 4
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic [15:0]     sdata,
  input  logic            svalid,
  output logic            sready,
  input  logic            slast,
  output logic [16*N-1:0] odata,
  output logic [N-1:0]    osel,
  output logic            ovalid,
  input  logic            oready,
  output logic            ostart,
  output logic            olast
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int VW = 16 * N;

`ifdef OPERAND_PACKER_PAD_ONE_EN
  localparam fp16_t PAD_WORD = FP16_ONE;
`else
  localparam fp16_t PAD_WORD = FP16_ZERO;
`endif

  localparam logic [VW-1:0] PAD_VEC   = {N{PAD_WORD}};
  localparam logic [CW-1:0] LAST_LANE = CW'(N - 1);

  col_state_t      state_q, state_d;
  logic [CW-1:0]   lane_q;
  logic [VW-1:0]   col_vec_q;
  logic [N-1:0]    col_sel_q;
  logic            col_start_q;
  logic            col_last_q;
  logic            start_armed_q;

  logic [VW-1:0]   out_vec_q;
  logic [N-1:0]    out_sel_q;
  logic            out_valid_q;
  logic            out_start_q;
  logic            out_last_q;

  logic            accept;
  logic            complete;
  logic            out_free;
  logic            load_in;
  logic            load_hold;
  logic            hold_en;
  logic [VW-1:0]   merged_vec;
  logic [N-1:0]    merged_sel;

  assign sready   = (state_q == COLLECT) && !areset;
  assign accept   = svalid && sready;
  assign complete = accept && (slast || (lane_q == LAST_LANE));
  assign out_free = !out_valid_q || oready;

  // Current collector contents with the incoming word dropped into its lane.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    merged_vec = col_vec_q;
    merged_sel = col_sel_q;
    for (int k = 0; k < N; k++) begin
      if (lane_q == CW'(k)) begin
        merged_vec[(N-1-k)*16 +: 16] = sdata;
        merged_sel[N-1-k]            = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_in   = 1'b0;
    load_hold = 1'b0;
    hold_en   = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (complete) begin
          if (out_free) begin
            load_in = 1'b1;
          end else begin
            hold_en = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          load_hold = 1'b1;
          state_d   = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge aclk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (areset) begin
      // NOTE: the lane storage is a handful of flops, so it is reset along with the control state.
      lane_q        <= '0;
      col_vec_q     <= PAD_VEC;
      col_sel_q     <= '0;
      col_start_q   <= 1'b0;
      col_last_q    <= 1'b0;
      start_armed_q <= 1'b1;
      out_vec_q     <= '0;
      out_sel_q     <= '0;
      out_valid_q   <= 1'b0;
      out_start_q   <= 1'b0;
      out_last_q    <= 1'b0;
    end else begin
      // Frame-start tracking advances in vector completion order.
      if (load_in || hold_en) begin
        start_armed_q <= slast;
      end

      if (accept && !complete) begin
        col_vec_q <= merged_vec;
        col_sel_q <= merged_sel;
        lane_q    <= lane_q + 1'b1;
      end

      if (hold_en) begin
        col_vec_q   <= merged_vec;
        col_sel_q   <= merged_sel;
        col_start_q <= start_armed_q;
        col_last_q  <= slast;
        lane_q      <= '0;
      end

      if (load_in) begin
        out_vec_q   <= merged_vec;
        out_sel_q   <= merged_sel;
        out_start_q <= start_armed_q;
        out_last_q  <= slast;
      end else if (load_hold) begin
        out_vec_q   <= col_vec_q;
        out_sel_q   <= col_sel_q;
        out_start_q <= col_start_q;
        out_last_q  <= col_last_q;
      end

      if (load_in || load_hold) begin
        col_vec_q   <= PAD_VEC;
        col_sel_q   <= '0;
        col_start_q <= 1'b0;
        col_last_q  <= 1'b0;
        lane_q      <= '0;
      end

      if (load_in || load_hold) begin
        out_valid_q <= 1'b1;
      end else if (oready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign odata  = out_vec_q;
  assign osel   = out_sel_q;
  assign ovalid = out_valid_q;
  assign ostart = out_start_q;
  assign olast  = out_last_q;

endmodule : operand_packer

// File: tb/tb_operand_packer.sv
// Self-checking bench for operand_packer: directed table, multi-cycle sequences, random scoreboard.
module tb_operand_packer;

  localparam int N = 4;
  localparam int W = 16 * N;

`ifdef OPERAND_PACKER_PAD_ONE_EN
  localparam logic [15:0] PAD = 16'h3C00;
`else
  localparam logic [15:0] PAD = 16'h0000;
`endif

  logic          aclk = 1'b0;
  logic          areset;
  logic [15:0]   sdata;
  logic          svalid;
  logic          sready;
  logic          slast;
  logic [W-1:0]  odata;
  logic [N-1:0]  osel;
  logic          ovalid;
  logic          oready;
  logic          ostart;
  logic          olast;

  int tests = 0;
  int fails = 0;

  operand_packer #(.N(N)) dut (
    .aclk   (aclk),
    .areset (areset),
    .sdata  (sdata),
    .svalid (svalid),
    .sready (sready),
    .slast  (slast),
    .odata  (odata),
    .osel   (osel),
    .ovalid (ovalid),
    .oready (oready),
    .ostart (ostart),
    .olast  (olast)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Presents one word and holds it until it is accepted on a clock edge.
  task automatic send_word(input logic [15:0] w, input logic l);
    bit ok;
    sdata  = w;
    slast  = l;
    svalid = 1'b1;
    ok     = 1'b0;
    for (int n = 0; n < 30 && !ok; n++) begin
      ok = sready;
      tick();
    end
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int cycles);
    svalid = 1'b0;
    slast  = 1'b0;
    repeat (cycles) tick();
  endtask

  // ---------------- reference model (random phase) ----------------
  typedef struct packed {
    logic [W-1:0] vec;
    logic [N-1:0] sel;
    logic         start;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  logic [15:0]  cur_q[$];
  bit           arm;
  bit           mon_en = 1'b0;
  bit           prev_stall;
  exp_t         prev_out;

  always @(negedge aclk) begin
    if (mon_en) begin
      if (prev_stall) begin
        check("stall_stable", {odata, osel, ostart, olast}, prev_out);
      end
      prev_stall = ovalid && !oready;
      prev_out   = '{vec: odata, sel: osel, start: ostart, last: olast};

      if (ovalid && oready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_vector", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rand_odata",  odata,  e.vec);
          check("rand_osel",   osel,   e.sel);
          check("rand_ostart", ostart, e.start);
          check("rand_olast",  olast,  e.last);
        end
      end

      if (svalid && sready) begin
        cur_q.push_back(sdata);
        if (slast || cur_q.size() == N) begin
          exp_t e;
          e.vec = '0;
          e.sel = '0;
          for (int i = 0; i < N; i++) begin
            e.vec = (e.vec << 16) | W'((i < cur_q.size()) ? cur_q[i] : PAD);
            e.sel = (e.sel << 1) | N'(i < cur_q.size());
          end
          e.start = arm;
          e.last  = slast;
          arm     = slast;
          exp_q.push_back(e);
          cur_q.delete();
        end
      end
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    int                  n;
    logic [3:0][15:0]    w;
    logic [W-1:0]        exp_vec;
    logic [N-1:0]        exp_sel;
  } tvec_t;

  tvec_t tbl[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v1, v2;
    int           nvec;

    tbl[0] = '{n: 4, w: {16'h4000, 16'h4200, 16'h4400, 16'h4500},
               exp_vec: 64'h4000_4200_4400_4500, exp_sel: 4'b1111};
    tbl[1] = '{n: 2, w: {16'h4000, 16'h4200, 16'h0, 16'h0},
               exp_vec: {16'h4000, 16'h4200, PAD, PAD}, exp_sel: 4'b1100};
    tbl[2] = '{n: 1, w: {16'h3800, 16'h0, 16'h0, 16'h0},
               exp_vec: {16'h3800, PAD, PAD, PAD}, exp_sel: 4'b1000};
    tbl[3] = '{n: 3, w: {16'h1234, 16'h5678, 16'h9ABC, 16'h0},
               exp_vec: {16'h1234, 16'h5678, 16'h9ABC, PAD}, exp_sel: 4'b1110};

    areset = 1'b1;
    svalid = 1'b0;
    slast  = 1'b0;
    sdata  = '0;
    oready = 1'b1;
    repeat (3) tick();
    check("rst_ovalid", ovalid, 0);
    check("rst_sready", sready, 0);
    check("rst_odata",  odata,  0);
    check("rst_flags",  {osel, ostart, olast}, 0);
    areset = 1'b0;
    #1;
    check("post_rst_sready", sready, 1);
    tick();

    // Single-vector frames: output must be valid right after the completing accept.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < tbl[t].n; i++) begin
        send_word(tbl[t].w[3-i], i == tbl[t].n - 1);
      end
      svalid = 1'b0;
      check($sformatf("tbl%0d_ovalid", t), ovalid, 1);
      check($sformatf("tbl%0d_odata",  t), odata,  tbl[t].exp_vec);
      check($sformatf("tbl%0d_osel",   t), osel,   tbl[t].exp_sel);
      check($sformatf("tbl%0d_flags",  t), {ostart, olast}, 2'b11);
      idle(2);
      check($sformatf("tbl%0d_cleared", t), ovalid, 0);
    end

    // 12-word frame, continuous flow.
    nvec = 0;
    for (int i = 0; i < 12; i++) begin
      check("f12_sready", sready, 1);
      send_word(16'h2000 + 16'(i), i == 11);
      if (ovalid) begin
        check("f12_odata", odata, {16'h2000 + 16'(nvec*4), 16'h2001 + 16'(nvec*4),
                                   16'h2002 + 16'(nvec*4), 16'h2003 + 16'(nvec*4)});
        check("f12_ostart", ostart, nvec == 0);
        check("f12_olast",  olast,  nvec == 2);
        nvec++;
      end
    end
    check("f12_count", nvec, 3);
    idle(2);

    // Backpressure: two vectors offered while the consumer stalls.
    oready = 1'b0;
    v1 = 64'h5000_5001_5002_5003;
    v2 = 64'h5004_5005_5006_5007;
    for (int i = 0; i < 8; i++) begin
      send_word(16'h5000 + 16'(i), i == 7);
      if (i == 3) begin
        check("bp_v1_valid", ovalid, 1);
        check("bp_v1_start", {ostart, olast}, 2'b10);
      end
      if (i >= 3) check("bp_v1_stable", {odata, osel}, {v1, 4'b1111});
    end
    svalid = 1'b0;
    check("bp_sready_low", sready, 0);
    check("bp_state_hold", dut.state_q, mpi_pkg::HOLD);
    repeat (2) begin
      tick();
      check("bp_v1_held", {odata, osel, ovalid, ostart, olast}, {v1, 4'b1111, 3'b110});
    end
    oready = 1'b1;
    tick();
    check("bp_v2_data",  {odata, osel}, {v2, 4'b1111});
    check("bp_v2_flags", {ovalid, ostart, olast}, 3'b101);
    check("bp_back_collect", sready, 1);
    tick();
    check("bp_drained", ovalid, 0);

    // Reset mid-frame discards the partial vector.
    send_word(16'hDEAD, 1'b0);
    send_word(16'hBEEF, 1'b0);
    svalid = 1'b0;
    areset = 1'b1;
    tick();
    check("mid_rst_out", {odata, osel, ovalid, ostart, olast}, 0);
    check("mid_rst_sready", sready, 0);
    areset = 1'b0;
    #1;
    check("mid_rst_release", sready, 1);
    for (int i = 0; i < 4; i++) send_word(16'h6000 + 16'(i), i == 3);
    svalid = 1'b0;
    check("post_rst_vec", {odata, osel}, {64'h6000_6001_6002_6003, 4'b1111});
    check("post_rst_flags", {ovalid, ostart, olast}, 3'b111);
    idle(2);

    // Random traffic against the scoreboard.
    areset = 1'b1;
    tick();
    areset = 1'b0;
    exp_q.delete();
    cur_q.delete();
    arm        = 1'b1;
    prev_stall = 1'b0;
    mon_en     = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      svalid = ($urandom_range(3) != 0);
      sdata  = 16'($urandom);
      slast  = ($urandom_range(6) == 0);
      oready = ($urandom_range(3) != 0);
      tick();
    end
    svalid = 1'b0;
    slast  = 1'b0;
    oready = 1'b1;
    repeat (10) tick();
    check("rand_drain", exp_q.size(), 0);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_operand_packer

// File: doc/operand_packer.md
OPERAND_PACKER -- requirements
Module: operand_packer

Interface
REQ-001 SHALL have parameter: N, 4, number of fp16 lanes in the output vector (N >= 1).
REQ-002 SHALL have port: aclk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: areset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: sdata  input  16  fp16 operand word.
REQ-005 SHALL have port: svalid  input  1  sdata valid.
REQ-006 SHALL have port: sready  output  1  word accepted when svalid && sready.
REQ-007 SHALL have port: slast  input  1  accepted word ends the current frame.
REQ-008 SHALL have port: odata  output  16*N  packed vector; lane 0 = bits [16N-1 -: 16].
REQ-009 SHALL have port: osel  output  N  lane-filled mask; lane k maps to bit N-1-k.
REQ-010 SHALL have port: ovalid  output  1  vector valid.
REQ-011 SHALL have port: oready  input  1  vector consumed when ovalid && oready.
REQ-012 SHALL have port: ostart  output  1  vector is the first of its frame.
REQ-013 SHALL have port: olast  output  1  vector is the last of its frame.

Function
REQ-014 SHALL fill lanes in order 0..N-1 from consecutive accepted words using a lane counter.
REQ-015 SHALL complete a vector when lane N-1 is filled or when a word with slast=1 is accepted.
REQ-016 SHALL set osel to 1 for filled lanes and 0 for unfilled lanes; unfilled-lane data per REQ-027/028.
REQ-017 SHALL have a collector FSM with states COLLECT (sready=1) and HOLD (sready=0).
REQ-018 SHALL, on the edge accepting a completing word with the output register empty or handshaking that cycle, load the vector into the output register (ovalid=1 next cycle), clear the collector, and stay in COLLECT.
REQ-019 SHALL otherwise enter HOLD, keep the completed vector, and on the first edge where the output register is empty or handshaking, transfer it and return to COLLECT.
REQ-020 SHALL hold odata, osel, ostart and olast stable while ovalid=1 and oready=0.
REQ-021 SHALL clear ovalid after a handshake when no new vector loads on the same edge.
REQ-022 SHALL set ostart=1 on the first vector after reset and on the first vector after an olast=1 vector.
REQ-023 SHALL set olast=1 on the vector containing the slast word; a single-vector frame has ostart=olast=1.
REQ-024 SHALL sustain one accepted word per cycle (one vector per N cycles) under continuous oready=1.
REQ-025 SHALL, with N=1, emit every accepted word as a full vector with osel=1.

Reset
REQ-026 SHALL, while areset=1 (including mid-frame), discard any partial or held vector, drive odata=0, osel=0, ovalid=0, ostart=0, olast=0, sready=0, set lane counter 0, state COLLECT, and arm ostart; sready=1 in the first cycle after areset falls.

Configuration
REQ-027 SHALL, with OPERAND_PACKER_PAD_ONE_EN defined, drive unfilled lanes with 16'h3C00 (fp16 1.0), making padded vectors neutral for product reduction.
REQ-028 SHALL, without OPERAND_PACKER_PAD_ONE_EN, drive unfilled lanes with 16'h0000; osel is identical in both builds.

Structure
REQ-029 SHALL take fp16_t (16-bit typedef), FP16_ONE (16'h3C00), FP16_ZERO and the collector state enum from the shared package mpi_pkg.
REQ-030 SHALL be a single module with no sub-modules; lane counter width $clog2(N) with a minimum of 1.

Verification
REQ-031 SHALL verify: N=4, oready=1, words 0x4000,0x4200,0x4400,0x4500 (last on 4th) -> one vector 0x4000_4200_4400_4500, osel=4'b1111, ostart=olast=1, ovalid one cycle after the 4th accept.
REQ-032 SHALL verify: N=4, words 0x4000,0x4200 with slast on 2nd, PAD_ONE_EN defined -> odata 0x4000_4200_3C00_3C00, osel=4'b1100; undefined -> 0x4000_4200_0000_0000.
REQ-033 SHALL verify: N=4, 12-word frame, oready=1 -> three vectors with ostart=1,0,0 and olast=0,0,1; sready continuously 1.
REQ-034 SHALL verify: oready=0 for 10 cycles while 8 words are offered -> first vector held stable, FSM in HOLD, sready=0 after the 8th accept; oready=1 -> both vectors delivered in order, none lost.
REQ-035 SHALL verify: areset pulsed after 2 words of a frame -> outputs zero, partial data discarded; next 4 words yield a vector with ostart=1 containing only post-reset words.
